// File: rtl/cpu_bus_datapath_if.sv
// Shared-bus bundle for the phase-1 datapath: per-source bus selects, load enables,
// ALU control, memory data input and every register's contents as seen by the bus mux.
interface cpu_bus_datapath_if #(
    parameter int WIDTH = 32
);
    logic [15:0]             Rout;
    logic [15:0]             Rin;
    logic                    HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
    logic                    HIin, LOin, Yin, Zin, MDRin;
    logic [11:0]             ALUControl;
    logic [WIDTH-1:0]        Mdatain;
    logic                    MDRRead;

    logic [WIDTH-1:0]        BusMuxOut;
    logic [15:0][WIDTH-1:0]  RMuxIn;
    logic [WIDTH-1:0]        HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn;
    logic [WIDTH-1:0]        PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn;
    logic [WIDTH-1:0]        Yout;

    modport master (
        output Rout, Rin, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
        output HIin, LOin, Yin, Zin, MDRin, ALUControl, Mdatain, MDRRead,
        input  BusMuxOut, RMuxIn, HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn,
        input  PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn, Yout
    );

    modport slave (
        input  Rout, Rin, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
        input  HIin, LOin, Yin, Zin, MDRin, ALUControl, Mdatain, MDRRead,
        output BusMuxOut, RMuxIn, HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn,
        output PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn, Yout
    );
endinterface

// File: rtl/cpu_bus_datapath.sv
// Phase-1 CPU datapath: register file, HI/LO/Y/Z/MDR, fixed-priority bus mux and a
// one-hot controlled ALU computing Y (op) bus into the 64-bit Z register.
module cpu_bus_datapath #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              clr,
    cpu_bus_datapath_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
        OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_NONE
    } alu_op_e;

    logic [15:0][WIDTH-1:0] r_gpr;
    logic [WIDTH-1:0]       r_hi, r_lo, r_y, r_mdr, r_pc, r_inport, r_c;
    logic [2*WIDTH-1:0]     r_z;

    logic [WIDTH-1:0]       w_bus;
    alu_op_e                w_op;
    logic [4:0]             w_sh;
    logic [2*WIDTH-1:0]     w_ror, w_rol, w_mul, w_alu;
    logic [WIDTH-1:0]       w_quo, w_rem, w_lo;

    // Lowest-priority sources are applied first so higher-priority ones overwrite them.
    always_comb begin
        w_bus = '0;
        if (bus.Cout)      w_bus = r_c;
        if (bus.InPortout) w_bus = r_inport;
        if (bus.MDRout)    w_bus = r_mdr;
        if (bus.PCout)     w_bus = r_pc;
        if (bus.Zlowout)   w_bus = r_z[WIDTH-1:0];
        if (bus.Zhighout)  w_bus = r_z[2*WIDTH-1:WIDTH];
        if (bus.LOout)     w_bus = r_lo;
        if (bus.HIout)     w_bus = r_hi;
        for (int unsigned i = 0; i < 16; i++) begin
            if (bus.Rout[15-i]) w_bus = r_gpr[15-i];
        end
    end

    always_comb begin
        w_op = OP_NONE;
        for (int unsigned i = 0; i < 12; i++) begin
            if (bus.ALUControl[11-i]) w_op = alu_op_e'(4'(11 - i));
        end
    end

    assign w_sh  = w_bus[4:0];
    assign w_ror = {r_y, r_y} >> w_sh;
    assign w_rol = {r_y, r_y} << w_sh;
    assign w_mul = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y}) * $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});

    always_comb begin
        w_quo = '0;
        w_rem = '0;
        if (w_bus != '0) begin
            w_quo = $signed(r_y) / $signed(w_bus);
            w_rem = $signed(r_y) % $signed(w_bus);
        end
    end

    always_comb begin
        w_lo  = '0;
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_lo = r_y + w_bus;
            OP_SUB:  w_lo = r_y - w_bus;
            OP_AND:  w_lo = r_y & w_bus;
            OP_OR:   w_lo = r_y | w_bus;
            OP_SHR:  w_lo = r_y >> w_sh;
            OP_SHL:  w_lo = r_y << w_sh;
            OP_ROR:  w_lo = w_ror[WIDTH-1:0];
            OP_ROL:  w_lo = w_rol[2*WIDTH-1:WIDTH];
            OP_NEG:  w_lo = '0 - w_bus;
            OP_NOT:  w_lo = ~w_bus;
            default: w_lo = '0;
        endcase
        if (w_op == OP_MUL)      w_alu = w_mul;
        else if (w_op == OP_DIV) w_alu = {w_rem, w_quo};
        else                     w_alu = {{WIDTH{1'b0}}, w_lo};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_gpr    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_mdr    <= '0;
            r_pc     <= '0;
            r_inport <= '0;
            r_c      <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (bus.Rin[i]) r_gpr[i] <= w_bus;
            end
            if (bus.HIin)  r_hi  <= w_bus;
            if (bus.LOin)  r_lo  <= w_bus;
            if (bus.Yin)   r_y   <= w_bus;
            if (bus.Zin)   r_z   <= w_alu;
            if (bus.MDRin) r_mdr <= bus.MDRRead ? bus.Mdatain : w_bus;
        end
    end

    assign bus.BusMuxOut   = w_bus;
    assign bus.RMuxIn      = r_gpr;
    assign bus.HIMuxIn     = r_hi;
    assign bus.LOMuxIn     = r_lo;
    assign bus.ZhighMuxIn  = r_z[2*WIDTH-1:WIDTH];
    assign bus.ZlowMuxIn   = r_z[WIDTH-1:0];
    assign bus.PCMuxIn     = r_pc;
    assign bus.MDRMuxIn    = r_mdr;
    assign bus.InPortMuxIn = r_inport;
    assign bus.CMuxIn      = r_c;
    assign bus.Yout        = r_y;
endmodule

// File: tb/tb_cpu_bus_datapath.sv
// Scoreboard bench for cpu_bus_datapath: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares them against the DUT.
module tb_cpu_bus_datapath;
    localparam int SIG_HI = 16, SIG_LO = 17, SIG_ZH = 18, SIG_ZL = 19, SIG_PC = 20;
    localparam int SIG_MDR = 21, SIG_INP = 22, SIG_C = 23, SIG_Y = 24, SIG_BUS = 25;

    typedef struct packed {
        logic        clr;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [7:0]  sout;  // HI, LO, Zhigh, Zlow, PC, MDR, InPort, C
        logic [4:0]  sin;   // HI, LO, Y, Z, MDR
        logic [11:0] alu;
        logic [31:0] mdat;
        logic        mdrrd;
    } ctl_t;

    typedef struct {
        string       name;
        int unsigned sig;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    cpu_bus_datapath_if #(.WIDTH(32)) dif ();
    cpu_bus_datapath #(.WIDTH(32)) dut (.clk(clk), .clr(clr), .bus(dif));

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] m_r[16];
    logic [31:0] m_hi = '0, m_lo = '0, m_y = '0, m_mdr = '0;
    logic [63:0] m_z = '0;
    ctl_t        cur;
    logic [31:0] cur_bus;
    logic [63:0] cur_alu;

    function automatic string sig_name(int unsigned s);
        case (s)
            SIG_HI:  return "HI";
            SIG_LO:  return "LO";
            SIG_ZH:  return "Zhigh";
            SIG_ZL:  return "Zlow";
            SIG_PC:  return "PC";
            SIG_MDR: return "MDR";
            SIG_INP: return "InPort";
            SIG_C:   return "C";
            SIG_Y:   return "Y";
            SIG_BUS: return "BusMuxOut";
            default: return $sformatf("R%0d", s);
        endcase
    endfunction

    function automatic logic [31:0] observe(int unsigned s);
        case (s)
            SIG_HI:  return dif.HIMuxIn;
            SIG_LO:  return dif.LOMuxIn;
            SIG_ZH:  return dif.ZhighMuxIn;
            SIG_ZL:  return dif.ZlowMuxIn;
            SIG_PC:  return dif.PCMuxIn;
            SIG_MDR: return dif.MDRMuxIn;
            SIG_INP: return dif.InPortMuxIn;
            SIG_C:   return dif.CMuxIn;
            SIG_Y:   return dif.Yout;
            SIG_BUS: return dif.BusMuxOut;
            default: return dif.RMuxIn[s];
        endcase
    endfunction

    function automatic logic [31:0] model_val(int unsigned s);
        case (s)
            SIG_HI:  return m_hi;
            SIG_LO:  return m_lo;
            SIG_ZH:  return m_z[63:32];
            SIG_ZL:  return m_z[31:0];
            SIG_MDR: return m_mdr;
            SIG_Y:   return m_y;
            SIG_PC, SIG_INP, SIG_C: return 32'h0;
            default: return m_r[s];
        endcase
    endfunction

    // Walk the source list from highest to lowest priority; first asserted select wins.
    function automatic logic [31:0] model_bus(ctl_t c);
        for (int i = 0; i < 16; i++) if (c.rout[i]) return m_r[i];
        if (c.sout[0]) return m_hi;
        if (c.sout[1]) return m_lo;
        if (c.sout[2]) return m_z[63:32];
        if (c.sout[3]) return m_z[31:0];
        if (c.sout[4]) return 32'h0;
        if (c.sout[5]) return m_mdr;
        return 32'h0;
    endfunction

    function automatic logic [63:0] model_alu(logic [11:0] ctl, logic [31:0] a, logic [31:0] b);
        int          k = -1;
        int unsigned s = b[4:0];
        logic [31:0] r32;
        int          sa, sb, q, r;
        longint      p;
        for (int i = 11; i >= 0; i--) if (ctl[i]) k = i;
        sa = a;
        sb = b;
        case (k)
            0:  r32 = a + b;
            1:  r32 = a - b;
            2:  r32 = a & b;
            3:  r32 = a | b;
            4:  r32 = a >> s;
            5:  r32 = a << s;
            6:  r32 = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            7:  r32 = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            8: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            9: begin
                if (sb == 0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            10: r32 = 32'h0 - b;
            11: r32 = ~b;
            default: r32 = 32'h0;
        endcase
        return {32'h0, r32};
    endfunction

    task automatic push(input string name, input int unsigned s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic ctl_t idle();
        ctl_t c = '0;
        return c;
    endfunction

    task automatic drive(input ctl_t c);
        cur = c;
        clr = c.clr;
        dif.Rout = c.rout;
        dif.Rin = c.rin;
        {dif.Cout, dif.InPortout, dif.MDRout, dif.PCout,
         dif.Zlowout, dif.Zhighout, dif.LOout, dif.HIout} = c.sout;
        {dif.MDRin, dif.Zin, dif.Yin, dif.LOin, dif.HIin} = c.sin;
        dif.ALUControl = c.alu;
        dif.Mdatain = c.mdat;
        dif.MDRRead = c.mdrrd;
        cur_bus = model_bus(c);
        cur_alu = model_alu(c.alu, m_y, cur_bus);
        push("bus", SIG_BUS, cur_bus);
    endtask

    task automatic finish_edge();
        @(posedge clk);
        if (cur.clr) begin
            for (int i = 0; i < 16; i++) m_r[i] = '0;
            m_hi = '0; m_lo = '0; m_y = '0; m_mdr = '0; m_z = '0;
        end else begin
            for (int i = 0; i < 16; i++) if (cur.rin[i]) m_r[i] = cur_bus;
            if (cur.sin[0]) m_hi = cur_bus;
            if (cur.sin[1]) m_lo = cur_bus;
            if (cur.sin[2]) m_y = cur_bus;
            if (cur.sin[3]) m_z = cur_alu;
            if (cur.sin[4]) m_mdr = cur.mdrrd ? cur.mdat : cur_bus;
        end
        #1;
        for (int unsigned s = 0; s < SIG_BUS; s++) push(sig_name(s), s, model_val(s));
    endtask

    task automatic step(input ctl_t c);
        drive(c);
        finish_edge();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        ctl_t c = idle();
        c.mdat = v; c.mdrrd = 1'b1; c.sin[4] = 1'b1;
        step(c);
        c = idle();
        c.sout[5] = 1'b1; c.rin[idx] = 1'b1;
        step(c);
    endtask

    task automatic load_y(input int idx);
        ctl_t c = idle();
        c.rout[idx] = 1'b1; c.sin[2] = 1'b1;
        step(c);
    endtask

    task automatic alu_op(input int idx, input logic [11:0] op);
        ctl_t c = idle();
        c.rout[idx] = 1'b1; c.alu = op; c.sin[3] = 1'b1;
        step(c);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = observe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h at %0t", e.name, got, e.val, $time);
                end
            end
        end
    end

    initial begin : stimulus
        ctl_t c;
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        clr = 1'b0;
        drive(idle());
        void'(sb.pop_back());
        @(posedge clk);
        #1;

        c = idle(); c.clr = 1'b1;
        step(c);
        push("reset_bus", SIG_BUS, 32'h0);

        load_reg(2, 32'h29);
        push("sub_r2", 2, 32'h29);
        load_reg(4, 32'h24);
        load_y(2);
        push("sub_y", SIG_Y, 32'h29);
        alu_op(4, 12'h002);
        push("sub_zl", SIG_ZL, 32'h5);
        push("sub_zh", SIG_ZH, 32'h0);
        c = idle(); c.sout[3] = 1'b1; c.rin[5] = 1'b1;
        step(c);
        push("sub_r5", 5, 32'h5);

        load_reg(6, 32'hFFFF_FFFE);
        load_reg(7, 32'h3);
        load_y(6);
        alu_op(7, 12'h100);
        push("mul_zh", SIG_ZH, 32'hFFFF_FFFF);
        push("mul_zl", SIG_ZL, 32'hFFFF_FFFA);

        load_y(2);
        alu_op(4, 12'h200);
        push("div_zl", SIG_ZL, 32'h1);
        push("div_zh", SIG_ZH, 32'h5);
        alu_op(0, 12'h200);
        push("div0_zl", SIG_ZL, 32'h0);
        push("div0_zh", SIG_ZH, 32'h0);

        load_reg(1, 32'hA);
        load_reg(3, 32'hB);
        c = idle(); c.rout[1] = 1'b1; c.rout[3] = 1'b1;
        drive(c);
        push("prio_bus", SIG_BUS, 32'hA);
        finish_edge();
        drive(idle());
        push("nosel_bus", SIG_BUS, 32'h0);
        finish_edge();

        c = idle(); c.rout[1] = 1'b1; c.rin[10] = 1'b1; c.rin[11] = 1'b1; c.sin[0] = 1'b1; c.sin[1] = 1'b1;
        step(c);
        push("multi_hi", SIG_HI, 32'hA);

        load_reg(8, 32'h8000_0001);
        load_reg(9, 32'h1);
        load_y(8);
        alu_op(9, 12'h040);
        push("ror_zl", SIG_ZL, 32'hC000_0000);
        alu_op(9, 12'h080);
        push("rol_zl", SIG_ZL, 32'h0000_0003);
        alu_op(9, 12'h010);
        push("shr_zl", SIG_ZL, 32'h4000_0000);
        c = idle(); c.clr = 1'b1; c.rout[9] = 1'b1; c.sin[3] = 1'b1; c.sin[2] = 1'b1; c.alu = 12'h001;
        step(c);
        push("clr_zl", SIG_ZL, 32'h0);
        push("clr_y", SIG_Y, 32'h0);
        push("clr_r9", 9, 32'h0);

        for (int n = 0; n < 400; n++) begin
            c = idle();
            c.clr = ($urandom_range(0, 59) == 0);
            repeat ($urandom_range(0, 2)) c.rout[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 2) == 0) c.sout[$urandom_range(0, 7)] = 1'b1;
            c.rin = 16'($urandom) & 16'($urandom) & 16'($urandom);
            c.sin = 5'($urandom) & 5'($urandom);
            case ($urandom_range(0, 3))
                0:       c.alu = 12'($urandom);
                1:       c.alu = 12'h0;
                default: c.alu = 12'(1 << $urandom_range(0, 11));
            endcase
            c.mdat = $urandom;
            c.mdrrd = 1'($urandom_range(0, 1));
            step(c);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
